// File: rtl/beat_gen_if.sv
// beat_gen_if: control and status bundle for the beat_gen tick generator.
// The master side (system or testbench) drives enable/load/period/mode;
// the slave side (beat_gen) returns the beat pulse, phase, busy and tally.
interface beat_gen_if #(
  parameter int WIDTH   = 5,
  parameter int BEATS_W = 8
) ();

  logic               enable;
  logic               load;
  logic [WIDTH-1:0]   period_m1;
  logic               one_shot;
  logic               count_en;
  logic [WIDTH-1:0]   phase;
  logic               busy;
  logic [BEATS_W-1:0] beats;

  modport master (
    output enable, load, period_m1, one_shot,
    input  count_en, phase, busy, beats
  );

  modport slave (
    input  enable, load, period_m1, one_shot,
    output count_en, phase, busy, beats
  );

endinterface

// File: rtl/beat_gen.sv
// beat_gen: programmable beat/tick generator, drop-in successor of beat32.
// Pulses count_en for one cycle every (period_m1+1) enabled cycles, either
// periodically or once (one-shot, then parks in DONE until reloaded).
// Reset restores a free-running divide-by-(DEFAULT_PERIOD_M1+1) behaviour.
//
// Build option: define BEAT_GEN_TALLY_EN to implement the beat tally
// register; otherwise the beats output is tied to zero.
module beat_gen #(
  parameter int WIDTH             = 5,
  parameter int DEFAULT_PERIOD_M1 = 31,
  parameter int BEATS_W           = 8
) (
  input  logic            clk,
  input  logic            reset,
  beat_gen_if.slave       bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;

  // A beat happens when running and the phase has reached the period end.
  // This decode is from registered state; reset and enable only gate it.
  logic             at_end;
  logic             beat_fire;

  assign at_end    = (state_q == ST_RUN) && (phase_q == period_q);
  assign beat_fire = bus.enable && at_end;

  // Next-state logic: load restarts, enable low freezes, otherwise advance.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    period_d = period_q;
    mode_d   = mode_q;
    if (bus.load) begin
      period_d = bus.period_m1;
      mode_d   = bus.one_shot;
      phase_d  = {WIDTH{1'b0}};
      state_d  = ST_RUN;
    end else if (!bus.enable) begin
      state_d  = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (phase_q == period_q) begin
            // Phase never exceeds period_q, so wrap here instead of overflowing.
            phase_d = {WIDTH{1'b0}};
            if (mode_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            phase_d = phase_q + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          phase_d = {WIDTH{1'b0}};
          state_d = ST_DONE;
        end
        default: begin
          phase_d = {WIDTH{1'b0}};
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State registers with synchronous reset to the beat32-compatible setup.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      phase_q  <= {WIDTH{1'b0}};
      period_q <= WIDTH'(DEFAULT_PERIOD_M1);
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

`ifdef BEAT_GEN_TALLY_EN
  logic [BEATS_W-1:0] beats_q, beats_d;

  // Tally: cleared by load, counts beats modulo 2^BEATS_W otherwise.
  always_comb begin
    beats_d = beats_q;
    if (bus.load) begin
      beats_d = {BEATS_W{1'b0}};
    end else if (beat_fire) begin
      beats_d = beats_q + {{(BEATS_W-1){1'b0}}, 1'b1};
    end else begin
      beats_d = beats_q;
    end
  end

  // Tally register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats_q <= {BEATS_W{1'b0}};
    end else begin
      beats_q <= beats_d;
    end
  end

  assign bus.beats = beats_q;
`else
  assign bus.beats = {BEATS_W{1'b0}};
`endif

  // Reset masks a pulse that the registered state would otherwise produce.
  assign bus.count_en = ~reset & beat_fire;
  assign bus.phase    = phase_q;
  assign bus.busy     = (state_q == ST_RUN);

endmodule

// File: tb/tb_beat_gen.sv
// tb_beat_gen: self-checking bench for beat_gen. A behavioural model counts
// enabled cycles since the last restart and derives phase, pulse, busy and
// tally arithmetically. Works with or without BEAT_GEN_TALLY_EN.
module tb_beat_gen;

  logic clk = 1'b0;
  logic reset;

  beat_gen_if #(.WIDTH(5), .BEATS_W(8)) bif ();

  beat_gen #(.WIDTH(5), .DEFAULT_PERIOD_M1(31), .BEATS_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Current stimulus (mirrored onto the DUT inputs)
  logic       rst_i = 1'b1, en_i = 1'b0, ld_i = 1'b0, os_i = 1'b0;
  logic [4:0] pm_i = 5'd0;

  // Model: enabled cycles since restart, period length, one-shot flag
  longint cnt  = 0;
  int     p    = 32;
  bit     os_m = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [14:0] obs, expv;

  // Model update on every rising edge
  always @(posedge clk) begin
    if (rst_i) begin
      cnt = 0; p = 32; os_m = 1'b0;
    end else if (ld_i) begin
      cnt = 0; p = int'(pm_i) + 1; os_m = os_i;
    end else if (en_i) begin
      cnt = cnt + 1;
    end
  end

  // Expected {count_en, busy, phase, beats} from the model for this cycle
  function automatic logic [14:0] exp_vec();
    bit         done;
    longint     ph;
    logic       ce;
    logic [7:0] b;
    done = os_m && (cnt >= p);
    ph   = done ? 0 : (cnt % p);
    ce   = !rst_i && en_i && !done && ((cnt % p) == p - 1);
`ifdef BEAT_GEN_TALLY_EN
    if (os_m) b = (cnt >= p) ? 8'd1 : 8'd0;
    else      b = 8'((cnt / p) % 256);
`else
    b = 8'd0;
`endif
    return {ce, !done, 5'(ph), b};
  endfunction

  // Apply one cycle of stimulus after the falling edge, then let it settle
  task automatic drive(input logic r, input logic e, input logic l,
                       input logic [4:0] pm, input logic o);
    @(negedge clk);
    rst_i = r; en_i = e; ld_i = l; pm_i = pm; os_i = o;
    reset = r; bif.enable = e; bif.load = l; bif.period_m1 = pm; bif.one_shot = o;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      total++;
      if ({bif.count_en, bif.busy, bif.phase, bif.beats} !== {1'b0, 1'b1, 5'd0, 8'd0}) begin
        $display("FAIL reset_state c%0d got %h want %h", i,
                 {bif.count_en, bif.busy, bif.phase, bif.beats}, {1'b0, 1'b1, 5'd0, 8'd0});
      end else passed++;
    end
    for (int c = 0; c < 100; c++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      obs = {bif.count_en, bif.busy, bif.phase, bif.beats}; expv = exp_vec();
      total++;
      if (obs !== expv) $display("FAIL free_run_model c%0d got %h want %h", c, obs, expv);
      else passed++;
      total++;
      if ({bif.count_en, bif.phase} !== {(c == 31 || c == 63 || c == 95), 5'(c % 32)})
        $display("FAIL free_run_pulse c%0d got ce=%b ph=%0d want ce=%b ph=%0d", c,
                 bif.count_en, bif.phase, (c == 31 || c == 63 || c == 95), c % 32);
      else passed++;
    end
  endtask

  task automatic test_periodic();
    drive(1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      obs = {bif.count_en, bif.busy, bif.phase, bif.beats}; expv = exp_vec();
      total++;
      if (obs !== expv) $display("FAIL periodic_model k%0d got %h want %h", k, obs, expv);
      else passed++;
      total++;
      if ({bif.count_en, bif.busy} !== {(k == 5 || k == 10 || k == 15), 1'b1})
        $display("FAIL periodic_pulse k%0d got ce=%b busy=%b want ce=%b busy=1", k,
                 bif.count_en, bif.busy, (k == 5 || k == 10 || k == 15));
      else passed++;
    end
  endtask

  task automatic test_one_shot();
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b0, 1'b1, 1'b1, 5'd2, 1'b1);
      for (int k = 1; k <= 24; k++) begin
        drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        obs = {bif.count_en, bif.busy, bif.phase, bif.beats}; expv = exp_vec();
        total++;
        if (obs !== expv) $display("FAIL one_shot_model p%0d k%0d got %h want %h", pass, k, obs, expv);
        else passed++;
        total++;
        if ({bif.count_en, bif.busy} !== {(k == 3), (k < 4)})
          $display("FAIL one_shot_pulse p%0d k%0d got ce=%b busy=%b want ce=%b busy=%b", pass, k,
                   bif.count_en, bif.busy, (k == 3), (k < 4));
        else passed++;
      end
    end
  endtask

  task automatic test_enable_gap();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 46; c++) begin
      drive(1'b0, !(c >= 10 && c < 17), 1'b0, 5'd0, 1'b0);
      obs = {bif.count_en, bif.busy, bif.phase, bif.beats}; expv = exp_vec();
      total++;
      if (obs !== expv) $display("FAIL enable_gap_model c%0d got %h want %h", c, obs, expv);
      else passed++;
      total++;
      if (bif.count_en !== (c == 38))
        $display("FAIL enable_gap_pulse c%0d got %b want %b", c, bif.count_en, (c == 38));
      else passed++;
      if (c >= 10 && c <= 17) begin
        total++;
        if (bif.phase !== 5'd10) $display("FAIL enable_gap_hold c%0d got %0d want 10", c, bif.phase);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 31; c++) drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    total++;
    if ({bif.count_en, bif.phase} !== {1'b0, 5'd31})
      $display("FAIL reset_mid_pulse got ce=%b ph=%0d want ce=0 ph=31", bif.count_en, bif.phase);
    else passed++;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++;
    if ({bif.count_en, bif.busy, bif.phase, bif.beats} !== {1'b0, 1'b1, 5'd0, 8'd0})
      $display("FAIL reset_mid_after got %h want %h",
               {bif.count_en, bif.busy, bif.phase, bif.beats}, {1'b0, 1'b1, 5'd0, 8'd0});
    else passed++;
  endtask

  task automatic test_tally();
    logic [7:0] want;
    drive(1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    for (int k = 1; k <= 301; k++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      obs = {bif.count_en, bif.busy, bif.phase, bif.beats}; expv = exp_vec();
      total++;
      if (obs !== expv) $display("FAIL tally_model k%0d got %h want %h", k, obs, expv);
      else passed++;
    end
`ifdef BEAT_GEN_TALLY_EN
    want = 8'd44;
`else
    want = 8'd0;
`endif
    total++;
    if (bif.beats !== want) $display("FAIL tally_final got %0d want %0d", bif.beats, want);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, k[0], (k % 3) != 2, 5'(k % 2), k[1]);
      obs = {bif.count_en, bif.busy, bif.phase, bif.beats}; expv = exp_vec();
      total++;
      if (obs !== expv) $display("FAIL back_to_back k%0d got %h want %h", k, obs, expv);
      else passed++;
    end
    drive(1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    total++;
    if ({bif.busy, bif.phase, bif.beats} !== {1'b1, 5'd0, 8'd0})
      $display("FAIL reset_beats_load got %h want %h", {bif.busy, bif.phase, bif.beats}, {1'b1, 5'd0, 8'd0});
    else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 100) < 2, ($urandom % 100) < 80, ($urandom % 100) < 6,
            (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom % 6), 1'($urandom % 2));
      obs = {bif.count_en, bif.busy, bif.phase, bif.beats}; expv = exp_vec();
      total++;
      if (obs !== expv) $display("FAIL random k%0d got %h want %h", k, obs, expv);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bif.enable = 1'b0; bif.load = 1'b0; bif.period_m1 = 5'd0; bif.one_shot = 1'b0;
    test_reset();
    test_periodic();
    test_one_shot();
    test_enable_gap();
    test_reset_mid();
    test_tally();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
